// File: rtl/mem_arb_pkg.sv
// Shared constants for the fetch/data memory arbiter: FSM encoding, the abort
// read value and counter sizing.
package mem_arb_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] I_BUSY = 2'd1;
    localparam logic [1:0] D_BUSY = 2'd2;

    localparam logic [WORD_W-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    localparam int DEF_MAX_DATA_STREAK = 4;
    localparam int DEF_ACK_TIMEOUT     = 64;

    function automatic int cnt_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/fetch_mem_arbiter_fetch_buffer.sv
// One-entry instruction buffer: holds the last fetched word and its address,
// tells IF whether it may proceed, and drops the word once IF advances.
module fetch_buffer
    import mem_arb_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic [WORD_W-1:0] if_addr_i,
    input  logic              if_hold_i,
    input  logic              fill_i,
    input  logic [WORD_W-1:0] fill_addr_i,
    input  logic [WORD_W-1:0] fill_data_i,
    output logic [WORD_W-1:0] instr_o,
    output logic              stall_o
);

    logic [WORD_W-1:0] ibuf_q;
    logic [WORD_W-1:0] ibuf_d;
    logic [WORD_W-1:0] ibuf_addr_q;
    logic [WORD_W-1:0] ibuf_addr_d;
    logic              ibuf_valid_q;
    logic              ibuf_valid_d;
    logic              hit_s;

    assign hit_s   = ibuf_valid_q && (ibuf_addr_q == if_addr_i);
    assign stall_o = !hit_s;
    assign instr_o = ibuf_q;

    // Next-state: a completed matching fetch fills, an advancing IF consumes.
    always_comb begin
        ibuf_d       = ibuf_q;
        ibuf_addr_d  = ibuf_addr_q;
        ibuf_valid_d = ibuf_valid_q;
        if (fill_i) begin
            ibuf_d       = fill_data_i;
            ibuf_addr_d  = fill_addr_i;
            ibuf_valid_d = 1'b1;
        end else if (hit_s && !if_hold_i) begin
            ibuf_valid_d = 1'b0;
        end else begin
            ibuf_valid_d = ibuf_valid_q;
        end
    end

    // Buffer state registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ibuf_q       <= 32'h0000_0000;
            ibuf_addr_q  <= 32'h0000_0000;
            ibuf_valid_q <= 1'b0;
        end else begin
            ibuf_q       <= ibuf_d;
            ibuf_addr_q  <= ibuf_addr_d;
            ibuf_valid_q <= ibuf_valid_d;
        end
    end

endmodule

// File: rtl/fetch_mem_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between instruction
// fetch and data accesses; data wins, bounded by a starvation streak counter.
module fetch_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_STREAK = DEF_MAX_DATA_STREAK,
    parameter int ACK_TIMEOUT     = DEF_ACK_TIMEOUT
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [WORD_W-1:0] IF_addr,
    input  logic              IF_HOLD,
    output logic [WORD_W-1:0] IF_instr,
    output logic              IF_STALL,
    input  logic              D_req,
    input  logic              D_we,
    input  logic [WORD_W-1:0] D_addr,
    input  logic [WORD_W-1:0] D_wdata,
    output logic [WORD_W-1:0] D_rdata,
    output logic              D_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              BUS_ERR
);

    localparam int STREAK_W = cnt_width(MAX_DATA_STREAK);
    localparam int TMO_W    = cnt_width(ACK_TIMEOUT);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);
    localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(ACK_TIMEOUT - 1);

    logic [1:0]          state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [WORD_W-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [WORD_W-1:0]   d_rdata_q, d_rdata_d;
    logic                d_done_q, d_done_d;
    logic                bus_err_q, bus_err_d;
    logic                fill_s;
    logic                fetch_need_s;
    logic                data_grant_s;
    logic                fetch_grant_s;

    fetch_buffer u_fetch_buffer (
        .CLK         (CLK),
        .RESET       (RESET),
        .if_addr_i   (IF_addr),
        .if_hold_i   (IF_HOLD),
        .fill_i      (fill_s),
        .fill_addr_i (mem_addr_q),
        .fill_data_i (mem_rdata),
        .instr_o     (IF_instr),
        .stall_o     (fetch_need_s)
    );

    assign IF_STALL = fetch_need_s;

    // The streak limit only bites while a fetch is actually waiting. A held
    // D_req in its D_done cycle parks the bus so fetch cannot slip in there.
    assign data_grant_s  = D_req && !d_done_q && ((streak_q < STREAK_MAX) || !fetch_need_s);
    assign fetch_grant_s = fetch_need_s && !(D_req && d_done_q);

    // Grant decision, access tracking and timeout abort.
    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        tmo_d       = tmo_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        d_rdata_d   = d_rdata_q;
        d_done_d    = 1'b0;
        bus_err_d   = bus_err_q;
        fill_s      = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_grant_s) begin
                    state_d     = D_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = D_we;
                    mem_addr_d  = D_addr;
                    mem_wdata_d = D_wdata;
                    streak_d    = fetch_need_s ? (streak_q + STREAK_W'(1)) : STREAK_W'(0);
                    tmo_d       = TMO_W'(0);
                end else if (fetch_grant_s) begin
                    state_d    = I_BUSY;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = IF_addr;
                    streak_d   = STREAK_W'(0);
                    tmo_d      = TMO_W'(0);
                end else begin
                    state_d = IDLE;
                end
            end
            I_BUSY: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    fill_s    = (IF_addr == mem_addr_q);
                end else if (tmo_q == TMO_LAST) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            D_BUSY: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    d_done_d  = 1'b1;
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end else begin
                        d_rdata_d = d_rdata_q;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    d_done_d  = 1'b1;
                    d_rdata_d = TIMEOUT_DATA;
                    bus_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    // Arbiter state and registered memory/data-port outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            streak_q    <= STREAK_W'(0);
            tmo_q       <= TMO_W'(0);
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            d_rdata_q   <= 32'h0000_0000;
            d_done_q    <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            tmo_q       <= tmo_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            d_rdata_q   <= d_rdata_d;
            d_done_q    <= d_done_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign D_rdata   = d_rdata_q;
    assign D_done    = d_done_q;
    assign BUS_ERR   = bus_err_q;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Directed bench for fetch_mem_arbiter: behavioural memory with adjustable
// latency, scoreboards for expected memory grants and data completions.
module tb_fetch_mem_arbiter;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } grant_t;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] IF_addr;
    logic        IF_HOLD;
    logic [31:0] IF_instr;
    logic        IF_STALL;
    logic        D_req;
    logic        D_we;
    logic [31:0] D_addr;
    logic [31:0] D_wdata;
    logic [31:0] D_rdata;
    logic        D_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        BUS_ERR;

    int checks = 0;
    int errors = 0;

    int  mem_lat;
    bit  ack_en;
    bit  force_ack;
    int  wait_cnt = 0;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_addr  = 32'h0;
    logic [31:0] wr_data  = 32'h0;
    logic        prev_req = 1'b0;

    grant_t      exp_grant_q[$];
    logic [31:0] exp_data_q[$];

    always #5 CLK = ~CLK;

    fetch_mem_arbiter dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IF_addr   (IF_addr),
        .IF_HOLD   (IF_HOLD),
        .IF_instr  (IF_instr),
        .IF_STALL  (IF_STALL),
        .D_req     (D_req),
        .D_we      (D_we),
        .D_addr    (D_addr),
        .D_wdata   (D_wdata),
        .D_rdata   (D_rdata),
        .D_done    (D_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .BUS_ERR   (BUS_ERR)
    );

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'hA5A5_1234;
    endfunction

    // Memory image: address-derived words plus one writable location.
    assign mem_ack   = force_ack || (mem_req && ack_en && (wait_cnt == mem_lat));
    assign mem_rdata = (wr_valid && (mem_addr == wr_addr)) ? wr_data : pat(mem_addr);

    always @(posedge CLK) begin
        if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else                     wait_cnt <= 0;
        if (mem_req && mem_ack && mem_we) begin
            wr_valid <= 1'b1;
            wr_addr  <= mem_addr;
            wr_data  <= mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Grant scoreboard: every new mem_req must match the next expected access.
    always @(negedge CLK) begin
        prev_req <= mem_req;
        if (mem_req && !prev_req) begin
            check("grant_expected", 32'(exp_grant_q.size() != 0), 32'd1);
            if (exp_grant_q.size() != 0) begin
                check("grant_addr", mem_addr, exp_grant_q[0].addr);
                check_bit("grant_we", mem_we, exp_grant_q[0].we);
                if (exp_grant_q[0].we) check("grant_wdata", mem_wdata, exp_grant_q[0].wdata);
                exp_grant_q.delete(0);
            end
        end
    end

    // Data scoreboard: each D_done pulse carries the next expected D_rdata.
    always @(negedge CLK) begin
        if (D_done) begin
            check("done_expected", 32'(exp_data_q.size() != 0), 32'd1);
            if (exp_data_q.size() != 0) begin
                check("d_rdata", D_rdata, exp_data_q[0]);
                exp_data_q.delete(0);
            end
        end
    end

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge CLK);
            if (D_done) begin
                seen = 1'b1;
                break;
            end
        end
        check_bit(tag, seen, 1'b1);
    endtask

    task automatic data_access(input string tag, input logic we, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] exp_rd);
        @(posedge CLK);
        #1;
        D_req = 1'b1; D_we = we; D_addr = a; D_wdata = wd;
        exp_grant_q.push_back('{a, we, wd});
        exp_data_q.push_back(exp_rd);
        wait_done(tag);
        @(posedge CLK);
        #1;
        D_req = 1'b0; D_we = 1'b0;
    endtask

    task automatic fetch_seq(input logic [31:0] a);
        IF_addr = a;
        exp_grant_q.push_back('{a, 1'b0, 32'h0});
        @(negedge CLK);
        check_bit("if_stall_decide", IF_STALL, 1'b1);
        @(negedge CLK);
        check_bit("if_stall_busy", IF_STALL, 1'b1);
        @(negedge CLK);
        check_bit("if_stall_ready", IF_STALL, 1'b0);
        check("if_instr", IF_instr, pat(a));
    endtask

    initial begin
        int cycles;
        RESET = 1'b0; IF_addr = 32'hBFC0_0000; IF_HOLD = 1'b0;
        D_req = 1'b0; D_we = 1'b0; D_addr = 32'h0; D_wdata = 32'h0;
        mem_lat = 0; ack_en = 1'b1; force_ack = 1'b0;

        #2;
        check_bit("rst_mem_req", mem_req, 1'b0);
        check_bit("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check_bit("rst_d_done", D_done, 1'b0);
        check("rst_d_rdata", D_rdata, 32'h0);
        check("rst_if_instr", IF_instr, 32'h0);
        check_bit("rst_if_stall", IF_STALL, 1'b1);
        check_bit("rst_bus_err", BUS_ERR, 1'b0);

        // Zero-wait fetches of two consecutive addresses.
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b1;
        fetch_seq(32'hBFC0_0000);
        @(posedge CLK);
        #1;
        fetch_seq(32'hBFC0_0004);
        IF_HOLD = 1'b1;

        // Write then read back.
        data_access("done_write", 1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0000_0000);
        data_access("done_read20", 1'b0, 32'h0000_0020, 32'h0, 32'h1234_5678);

        // Held data read versus a pending fetch, 3-cycle memory.
        @(posedge CLK);
        #1;
        mem_lat = 2;
        IF_addr = 32'hBFC0_0008;
        D_req = 1'b1; D_we = 1'b0; D_addr = 32'h0000_1000;
        for (int i = 0; i < 4; i++) exp_grant_q.push_back('{32'h0000_1000, 1'b0, 32'h0});
        exp_grant_q.push_back('{32'hBFC0_0008, 1'b0, 32'h0});
        exp_grant_q.push_back('{32'h0000_1000, 1'b0, 32'h0});
        for (int i = 0; i < 5; i++) exp_data_q.push_back(pat(32'h0000_1000));
        for (int i = 0; i < 5; i++) wait_done("done_streak");
        @(posedge CLK);
        #1 D_req = 1'b0;
        @(negedge CLK);
        check_bit("streak_if_stall", IF_STALL, 1'b0);
        check("streak_if_instr", IF_instr, pat(32'hBFC0_0008));

        // Redirect while the fetch is outstanding.
        @(posedge CLK);
        #1 IF_addr = 32'hBFC0_0010;
        exp_grant_q.push_back('{32'hBFC0_0010, 1'b0, 32'h0});
        exp_grant_q.push_back('{32'h8000_0000, 1'b0, 32'h0});
        @(posedge CLK);
        #1 IF_addr = 32'h8000_0000;
        cycles = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge CLK);
            cycles++;
            if (!IF_STALL) break;
        end
        check("redirect_stall_cycles", cycles, 32'd8);
        check("redirect_if_instr", IF_instr, pat(32'h8000_0000));

        // Memory never acknowledges: abort after 64 request cycles.
        @(posedge CLK);
        #1;
        ack_en = 1'b0; mem_lat = 0;
        D_req = 1'b1; D_we = 1'b0; D_addr = 32'h0000_0040;
        exp_grant_q.push_back('{32'h0000_0040, 1'b0, 32'h0});
        exp_data_q.push_back(32'hDEAD_BEEF);
        cycles = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge CLK);
            if (mem_req) cycles++;
            if (D_done) break;
        end
        check_bit("timeout_done", D_done, 1'b1);
        check("timeout_req_cycles", cycles, 32'd64);
        check_bit("timeout_bus_err", BUS_ERR, 1'b1);
        @(posedge CLK);
        #1;
        D_req = 1'b0; ack_en = 1'b1;
        data_access("done_after_err", 1'b0, 32'h0000_0020, 32'h0, 32'h1234_5678);
        check_bit("bus_err_sticky", BUS_ERR, 1'b1);

        // Reset in the middle of a data access.
        @(posedge CLK);
        #1;
        ack_en = 1'b0;
        D_req = 1'b1; D_we = 1'b0; D_addr = 32'h0000_0080;
        exp_grant_q.push_back('{32'h0000_0080, 1'b0, 32'h0});
        @(posedge CLK);
        @(posedge CLK);
        #3 RESET = 1'b0;
        #1;
        check_bit("mid_rst_mem_req", mem_req, 1'b0);
        check_bit("mid_rst_if_stall", IF_STALL, 1'b1);
        check_bit("mid_rst_bus_err", BUS_ERR, 1'b0);
        check("mid_rst_d_rdata", D_rdata, 32'h0);
        check("mid_rst_if_instr", IF_instr, 32'h0);
        check("mid_rst_mem_addr", mem_addr, 32'h0);
        D_req = 1'b0;
        @(posedge CLK);
        #1;
        ack_en = 1'b1; force_ack = 1'b1; RESET = 1'b1;
        exp_grant_q.push_back('{32'h8000_0000, 1'b0, 32'h0});
        @(negedge CLK);
        check_bit("late_ack_req", mem_req, 1'b0);
        @(posedge CLK);
        #1 force_ack = 1'b0;
        @(negedge CLK);
        check_bit("late_ack_no_done", D_done, 1'b0);
        @(negedge CLK);
        check_bit("post_rst_if_stall", IF_STALL, 1'b0);
        check("post_rst_if_instr", IF_instr, pat(32'h8000_0000));
        data_access("done_post_rst", 1'b0, 32'h0000_0080, 32'h0, pat(32'h0000_0080));
        check_bit("post_rst_bus_err", BUS_ERR, 1'b0);

        repeat (3) @(posedge CLK);
        check("grants_left", exp_grant_q.size(), 32'd0);
        check("dones_left", exp_data_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule
